serial_subtractor: RTL

- Bit-serial N-bit subtractor; the inverse operation of the team's combinational full-adder path.
- Computes diff = a - b - bin, LSB first, one bit per clock, through a single 1-bit full-subtractor cell and a registered borrow.
- Start/busy/done handshake.
- Sits in the arithmetic library beside the adders as a low-area subtract unit for multi-cycle datapaths.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/full_subtractor_1bit.sv | 13 +
 rtl/serial_subtractor.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
package serial_subtractor_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_BUSY = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_BUSY = ENC_BUSY,
        ST_DONE = ENC_DONE
    } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; diff/bout hold the last result
// ST_BUSY | one operand bit per edge through the subtractor cell
// ST_DONE | done pulse for one cycle; start here restarts immediately
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             br_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             cell_d;
    logic             cell_bo;

    full_subtractor_1bit u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // Difference bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
    always_comb begin
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = cell_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= cell_bo;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        diff_q  <= res_d;
                        bout_q  <= cell_bo;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule
